// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: first-word-fall-through octet FIFO behind the serial receiver,
// with occupancy, full and a sticky overrun flag for writes dropped while full.
module serial_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr,
  input  logic [7:0]           i_data,
  output logic                 o_valid,
  output logic [7:0]           o_data,
  input  logic                 i_ready,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_full,
  output logic                 o_overrun,
  input  logic                 i_clr_ovr
);
  localparam logic [ADDR_BITS:0] ONE = 1;
  logic [7:0]         mem_q [DEPTH];
  logic [ADDR_BITS:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic               ovr_q, ovr_d, empty, full, push, pop;
  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  always_comb begin
    empty  = wptr_q == rptr_q;
    full   = (wptr_q[ADDR_BITS-1:0] == rptr_q[ADDR_BITS-1:0]) && (wptr_q[ADDR_BITS] != rptr_q[ADDR_BITS]);
    pop    = !empty && i_ready;
    push   = i_wr && (!full || pop);
    wptr_d = push ? wptr_q + ONE : wptr_q;
    rptr_d = pop ? rptr_q + ONE : rptr_q;
    ovr_d  = (i_wr && full && !pop) ? 1'b1 : (i_clr_ovr ? 1'b0 : ovr_q);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovr_q  <= ovr_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q[ADDR_BITS-1:0]] <= i_data;
  end
  assign o_valid   = !empty;
  assign o_data    = empty ? 8'h00 : mem_q[rptr_q[ADDR_BITS-1:0]];
  assign o_count   = wptr_q - rptr_q;
  assign o_full    = full;
  assign o_overrun = ovr_q;
endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb_serial_rx_fifo: directed steps against a queue scoreboard of accepted octets.
module tb_serial_rx_fifo;
  localparam int DEPTH = 16;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       i_wr = 1'b0, i_ready = 1'b0, i_clr_ovr = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_valid, o_full, o_overrun;
  logic [7:0] o_data;
  logic [4:0] o_count;
  int         total = 0, passed = 0;
  logic [7:0] sb [$];
  logic       movr = 1'b0;

  serial_rx_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(i_wr), .i_data(i_data),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_count(o_count), .o_full(o_full), .o_overrun(o_overrun), .i_clr_ovr(i_clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(o_count), 32'(sb.size()));
    check({tag, "_valid"}, 32'(o_valid), 32'(sb.size() != 0));
    check({tag, "_full"}, 32'(o_full), 32'(sb.size() == DEPTH));
    check({tag, "_ovr"}, 32'(o_overrun), 32'(movr));
    check({tag, "_head"}, 32'(o_data), sb.size() != 0 ? 32'(sb[0]) : 32'h0);
  endtask

  // Called #1 after an edge: drive inputs, score the pop, step one edge, check state.
  task automatic cycle(input logic wr, input logic [7:0] d, input logic rdy, input logic clr);
    logic mpop, mpush;
    i_wr = wr; i_data = d; i_ready = rdy; i_clr_ovr = clr;
    mpop  = (sb.size() != 0) && rdy;
    mpush = wr && (sb.size() < DEPTH || mpop);
    movr  = (wr && !mpush) ? 1'b1 : (clr ? 1'b0 : movr);
    if (mpop) check("pop_data", 32'(o_data), 32'(sb.pop_front()));
    if (mpush) sb.push_back(d);
    @(posedge clk); #1;
    check_state("cyc");
    i_wr = 1'b0; i_ready = 1'b0; i_clr_ovr = 1'b0;
  endtask

  initial begin
    int sent;
    #2;
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_count", 32'(o_count), 32'h0);
    check("rst_ovr", 32'(o_overrun), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_state("idle");
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    // single octet in and out
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check("single_data", 32'(o_data), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("single_empty", 32'(o_valid), 32'h0);
    // fill plus one dropped write, then drain and clear
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", 32'(o_full), 32'h1);
    check("fill_ovr", 32'(o_overrun), 32'h1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_empty", 32'(o_count), 32'h0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovr", 32'(o_overrun), 32'h0);
    // push into the slot freed by a same-cycle pop while full
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + 8'(i)), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    check("pp_count", 32'(o_count), 32'd16);
    check("pp_ovr", 32'(o_overrun), 32'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    // wrap-around stream with random consumer stalls
    sent = 0;
    for (int c = 0; c < 400 && (sent < 40 || sb.size() != 0); c++) begin
      logic w;
      w = (sent < 40) && (sb.size() < 12);
      cycle(w, 8'(sent) + 8'h80, 1'($urandom_range(0, 1)), 1'b0);
      if (w) sent++;
    end
    check("wrap_done", 32'(sent == 40 && sb.size() == 0), 32'h1);
    check("wrap_ovr", 32'(o_overrun), 32'h0);
    // overrun set and clear in the same cycle: set wins
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h40 + 8'(i)), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    check("coll_set", 32'(o_overrun), 32'h1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("coll_clr", 32'(o_overrun), 32'h0);
    // asynchronous reset mid-stream, between edges
    rst_n = 1'b0;
    #2;
    sb.delete();
    movr = 1'b0;
    check("async_valid", 32'(o_valid), 32'h0);
    check("async_data", 32'(o_data), 32'h0);
    check("async_count", 32'(o_count), 32'h0);
    check("async_full", 32'(o_full), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 8'h78, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_rx_fifo.md
Name: serial_rx_fifo

Overview:
Receive buffer directly downstream of the serial receiver. Captures each octet announced by the receiver's one-cycle write strobe into a power-of-two FIFO. Presents octets to the consumer through a first-word-fall-through valid/ready interface. Reports occupancy and a sticky overrun flag, so a slow consumer at 115200 baud loses no data silently.

Parameters:
DEPTH, 16, FIFO capacity in octets; power of two, minimum 2
ADDR_BITS, $clog2(DEPTH), derived; pointer index width (do not override)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_wr  input  1  write strobe from receiver; each cycle high is one write
i_data  input  8  octet to store, sampled when i_wr=1
o_valid  output  1  head octet available on o_data
o_data  output  8  head octet (FWFT); 0 when o_valid=0
i_ready  input  1  consumer accepts head; pop occurs when o_valid & i_ready
o_count  output  ADDR_BITS+1  octets currently stored, 0..DEPTH
o_full  output  1  o_count == DEPTH
o_overrun  output  1  sticky: a write was dropped
i_clr_ovr  input  1  synchronous clear of o_overrun

Behaviour:
- Reset (i_rst_n=0, asynchronous, effective immediately): write ptr=0, read ptr=0, o_count=0, o_valid=0, o_data=0, o_full=0, o_overrun=0. Storage array is not reset. Deassertion is taken as synchronous to i_clk.
- Pointers are ADDR_BITS+1 wide. Index = low ADDR_BITS bits. Extra MSB gives the wrap phase.
  - empty: ptrs equal
  - full: indices equal and MSBs differ
  - Pointers increment modulo 2^(ADDR_BITS+1) with natural wrap.
- o_count = wptr - rptr (modulo arithmetic), registered with the pointers.
- push = i_wr & (!o_full | pop). pop = o_valid & i_ready.
- Write latency: octet written at edge N appears on o_data with o_valid=1 after edge N, provided the FIFO was empty. One cycle, no bypass path.
- o_data = mem[rptr index] when o_valid=1, else 0. o_valid = !empty. Both are derived from registered state; no combinational path from i_wr/i_data.
- After a pop, the next octet (if any) is presented in the following cycle. Back-to-back pops at one per cycle are supported.
- Simultaneous push and pop:
  - Not empty: both occur, o_count unchanged.
  - Empty: pop impossible (o_valid=0), so push only.
  - Full with pop: push accepted into the freed slot, o_count stays DEPTH, order preserved.
- Overrun:
  - i_wr=1 while full and no pop: the octet is discarded.
  - Stored contents and pointers are unchanged.
  - o_overrun=1 from the next cycle.
  - o_overrun holds until a cycle with i_clr_ovr=1 and no new overrun.
  - Same-cycle set and clear: set wins.
- i_ready while o_valid=0 has no effect. i_wr=0 leaves i_data ignored.
- Reset mid-stream discards all contents. The first write after reset lands at index 0.

Test Plan:
- Reset then idle: o_valid=0, o_data=0x00, o_count=0, o_full=0, o_overrun=0; assert async reset between edges and require outputs to clear without a clock edge.
- Single octet: one-cycle i_wr with 0xA5, i_ready=0 -> next cycle o_valid=1, o_data=0xA5, o_count=1; then one cycle of i_ready=1 -> o_valid=0, o_count=0.
- Fill and overrun: 17 writes of 0x00..0x10, i_ready=0 -> o_full=1, o_count=16, o_overrun=1 after write 17; drain returns 0x00..0x0F in order, 0x10 absent; pulse i_clr_ovr -> o_overrun=0.
- Full with simultaneous push/pop: when full, i_wr=1 with 0x55 and i_ready=1 in the same cycle -> o_overrun stays 0, o_count stays 16; 0x55 emerges last in the drain.
- Wrap-around: 40 octets streamed with i_ready toggling in a pseudo-random pattern -> output sequence identical to input, o_count never exceeds 16, no overrun.
- Overrun set/clear collision: full FIFO, i_wr=1 and i_clr_ovr=1 in the same cycle -> o_overrun=1 next cycle; i_clr_ovr alone -> 0.
